// File: rtl/air_traffic_controller.sv
// Registered runway/gate arbiter: classifies requests, runs weather/fuel hold countdowns, and grants runway and gate.
// Optional gate occupancy tracking is enabled by defining ATC_GATE_TRACK_EN.
module air_traffic_controller #(
    parameter int unsigned WX_DELAY   = 12,
    parameter int unsigned FUEL_DELAY = 15,
    parameter int unsigned TICK_DIV   = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       weather,
    input  logic       speed,
    input  logic       range,
    input  logic       altitude,
    input  logic [1:0] fuel,
    input  logic       emergency,
    input  logic       takeoff_signal,
    input  logic [2:0] gate_number,
    output logic [1:0] allocated_runway,
    output logic [2:0] allocated_gate,
    output logic       timer_active,
    output logic [3:0] timer_value,
    output logic       alloc_valid
);

    localparam int unsigned PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    typedef enum logic [1:0] {
        IDLE,
        COUNT,
        GRANT
    } state_t;

    state_t      state, state_d;
    logic [PW-1:0] prescale, prescale_d;
    logic [7:0]  snap, snap_d;
    logic [1:0]  runway_d;
    logic [2:0]  gate_d;
    logic        active_d, valid_d;
    logic [3:0]  timer_d;

    logic        is_emerg, is_wx, is_xfuel, is_normal, tick;
    logic [1:0]  class_runway;
    logic [7:0]  req_snap;
    logic        gate_ok;
    logic [2:0]  grant_gate;
    logic        grant_req, grant_emerg;
    logic [1:0]  grant_runway;

    assign is_emerg     = emergency | (~takeoff_signal & (fuel == 2'b00));
    assign is_wx        = ~weather;
    assign is_xfuel     = ~takeoff_signal & (fuel == 2'b11);
    assign is_normal    = takeoff_signal | (speed & range & altitude);
    assign class_runway = takeoff_signal ? (gate_number[2] ? 2'd2 : 2'd3) : 2'd1;
    assign req_snap     = {takeoff_signal, gate_number, fuel, weather, emergency};
    assign tick         = (prescale == PW'(TICK_DIV - 1));

`ifdef ATC_GATE_TRACK_EN
    logic [7:0] occupancy, occupancy_d;
    logic [2:0] free_gate;
    logic       free_found;

    always_comb begin
        free_gate  = '0;
        free_found = 1'b0;
        for (int unsigned i = 0; i < 8; i++) begin
            if (!occupancy[i] && !free_found) begin
                free_gate  = 3'(i);
                free_found = 1'b1;
            end
        end
    end

    // A full field blocks ordinary landings; emergencies still get gate 7.
    assign gate_ok    = takeoff_signal | free_found;
    assign grant_gate = takeoff_signal ? gate_number : (free_found ? free_gate : 3'd7);
`else
    assign gate_ok    = 1'b1;
    assign grant_gate = gate_number;
`endif

    always_comb begin
        state_d      = state;
        prescale_d   = prescale;
        snap_d       = snap;
        runway_d     = allocated_runway;
        gate_d       = allocated_gate;
        active_d     = timer_active;
        valid_d      = alloc_valid;
        timer_d      = timer_value;
        grant_req    = 1'b0;
        grant_emerg  = 1'b0;
        grant_runway = class_runway;
`ifdef ATC_GATE_TRACK_EN
        occupancy_d  = occupancy;
`endif

        unique case (state)
            IDLE: begin
                valid_d = 1'b0;
                if (is_emerg) begin
                    grant_req    = 1'b1;
                    grant_emerg  = 1'b1;
                    grant_runway = 2'd0;
                end else if (is_wx || is_xfuel) begin
                    state_d    = COUNT;
                    timer_d    = is_wx ? 4'(WX_DELAY) : 4'(FUEL_DELAY);
                    active_d   = 1'b1;
                    prescale_d = '0;
                end else if (is_normal) begin
                    grant_req = 1'b1;
                end
            end
            COUNT: begin
                if (is_emerg) begin
                    grant_req    = 1'b1;
                    grant_emerg  = 1'b1;
                    grant_runway = 2'd0;
                end else begin
                    prescale_d = tick ? '0 : prescale + 1'b1;
                    if (tick) begin
                        if (timer_value == 4'd1) grant_req = 1'b1;
                        else                     timer_d   = timer_value - 4'd1;
                    end
                end
            end
            GRANT: begin
                if (req_snap != snap) begin
                    if (is_emerg) begin
                        grant_req    = 1'b1;
                        grant_emerg  = 1'b1;
                        grant_runway = 2'd0;
                    end else begin
                        state_d = IDLE;
                        valid_d = 1'b0;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // All grant paths converge here; a refused landing falls back to IDLE with the timer cleared.
        if (grant_req) begin
            timer_d    = '0;
            active_d   = 1'b0;
            prescale_d = '0;
            if (grant_emerg || gate_ok) begin
                state_d  = GRANT;
                valid_d  = 1'b1;
                runway_d = grant_runway;
                gate_d   = grant_gate;
                snap_d   = req_snap;
`ifdef ATC_GATE_TRACK_EN
                if (takeoff_signal)  occupancy_d[gate_number] = 1'b0;
                else if (free_found) occupancy_d[free_gate]   = 1'b1;
`endif
            end else begin
                state_d = IDLE;
                valid_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state            <= IDLE;
            prescale         <= '0;
            snap             <= '0;
            allocated_runway <= '0;
            allocated_gate   <= '0;
            timer_active     <= 1'b0;
            timer_value      <= '0;
            alloc_valid      <= 1'b0;
`ifdef ATC_GATE_TRACK_EN
            occupancy        <= '0;
`endif
        end else begin
            state            <= state_d;
            prescale         <= prescale_d;
            snap             <= snap_d;
            allocated_runway <= runway_d;
            allocated_gate   <= gate_d;
            timer_active     <= active_d;
            timer_value      <= timer_d;
            alloc_valid      <= valid_d;
`ifdef ATC_GATE_TRACK_EN
            occupancy        <= occupancy_d;
`endif
        end
    end

endmodule

// File: tb/tb_air_traffic_controller.sv
// Bench for air_traffic_controller: behavioural reference model checked every cycle, plus directed literal checks.
// Covers the ATC_GATE_TRACK_EN build as well when that macro is defined.
module tb_air_traffic_controller;

    localparam int unsigned WXD = 12;
    localparam int unsigned FD  = 15;
    localparam int unsigned TD  = 2;

    bit         clk = 1'b0;
    logic       rst = 1'b1;
    logic       weather = 1'b1, speed = 1'b1, range = 1'b1, altitude = 1'b1;
    logic [1:0] fuel = 2'b01;
    logic       emergency = 1'b0, takeoff_signal = 1'b0;
    logic [2:0] gate_number = 3'd0;
    logic [1:0] allocated_runway;
    logic [2:0] allocated_gate;
    logic       timer_active;
    logic [3:0] timer_value;
    logic       alloc_valid;

    int n_cmp = 0;
    int n_bad = 0;
    bit started = 1'b0;

    always #5 clk = ~clk;

    air_traffic_controller #(.WX_DELAY(WXD), .FUEL_DELAY(FD), .TICK_DIV(TD)) dut (
        .clk(clk), .rst(rst), .weather(weather), .speed(speed), .range(range),
        .altitude(altitude), .fuel(fuel), .emergency(emergency),
        .takeoff_signal(takeoff_signal), .gate_number(gate_number),
        .allocated_runway(allocated_runway), .allocated_gate(allocated_gate),
        .timer_active(timer_active), .timer_value(timer_value), .alloc_valid(alloc_valid)
    );

    task automatic check(input string name, input int got, input int want);
        n_cmp++;
        if (got != want) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, got, want, $time);
        end
    endtask

    // Reference model: a tower clerk holding a pending hold count and the request it last granted.
    bit         m_granted;
    int         m_hold, m_tick;
    logic [7:0] m_held;
    int         m_rwy, m_gate;
    bit         m_busy [8];

    task automatic m_grant(input int rwy, input bit em, input logic [7:0] req);
        int g;
        g = -1;
        m_hold = 0;
        m_tick = 0;
        if (takeoff_signal) begin
            g = gate_number;
`ifdef ATC_GATE_TRACK_EN
            m_busy[gate_number] = 1'b0;
`endif
        end else begin
`ifdef ATC_GATE_TRACK_EN
            for (int i = 0; i < 8; i++) if (!m_busy[i] && g < 0) g = i;
            if (g < 0) begin
                if (!em) begin
                    m_granted = 1'b0;
                    return;
                end
                g = 7;
            end else m_busy[g] = 1'b1;
`else
            g = gate_number;
`endif
        end
        m_granted = 1'b1;
        m_held    = req;
        m_rwy     = rwy;
        m_gate    = g;
    endtask

    always @(posedge clk) begin : model
        logic [7:0] req;
        bit em, wx, xf, nm;
        int crw;
        started = 1'b1;
        if (rst) begin
            m_granted = 1'b0; m_hold = 0; m_tick = 0; m_rwy = 0; m_gate = 0; m_held = '0;
            for (int i = 0; i < 8; i++) m_busy[i] = 1'b0;
        end else begin
            req = {takeoff_signal, gate_number, fuel, weather, emergency};
            em  = emergency || (!takeoff_signal && fuel == 2'b00);
            wx  = !weather;
            xf  = !takeoff_signal && fuel == 2'b11;
            nm  = takeoff_signal || (speed && range && altitude);
            crw = !takeoff_signal ? 1 : (gate_number >= 3'd4 ? 2 : 3);
            if (m_granted && req == m_held) begin
                // unchanged request: keep the grant
            end else if (em) begin
                m_grant(0, 1'b1, req);
            end else if (m_granted) begin
                m_granted = 1'b0;
            end else if (m_hold > 0) begin
                m_tick++;
                if (m_tick == TD) begin
                    m_tick = 0;
                    m_hold--;
                    if (m_hold == 0) m_grant(crw, 1'b0, req);
                end
            end else if (wx) begin
                m_hold = WXD; m_tick = 0;
            end else if (xf) begin
                m_hold = FD; m_tick = 0;
            end else if (nm) begin
                m_grant(crw, 1'b0, req);
            end
        end
    end

    always @(negedge clk) begin
        if (started) begin
            check("alloc_valid", alloc_valid, m_granted);
            check("timer_active", timer_active, m_hold > 0);
            check("timer_value", timer_value, m_hold);
            if (m_granted) begin
                check("allocated_runway", allocated_runway, m_rwy);
                check("allocated_gate", allocated_gate, m_gate);
            end
        end
    end

    task automatic wait_valid(input string name, input int budget);
        int k;
        for (k = 0; k < budget; k++) begin
            @(negedge clk);
            if (alloc_valid) break;
        end
        if (k == budget) begin
            n_cmp++;
            n_bad++;
            $display("FAIL %s: alloc_valid still 0 after %0d cycles, expected 1", name, budget);
        end
    endtask

    initial begin
        // Reset
        @(negedge clk);
        check("rst_runway", allocated_runway, 0);
        check("rst_gate", allocated_gate, 0);
        check("rst_timer_active", timer_active, 0);
        check("rst_timer_value", timer_value, 0);
        check("rst_valid", alloc_valid, 0);
        rst = 1'b0;
        emergency = 1'b1;

        // Emergency landing, then fuel shortage as the emergency reason
        @(negedge clk);
        check("emerg_runway", allocated_runway, 0);
        check("emerg_valid", alloc_valid, 1);
        emergency = 1'b0;
        fuel = 2'b00;
        @(negedge clk);
        check("fuel_short_runway", allocated_runway, 0);
        check("fuel_short_valid", alloc_valid, 1);

        // Drop to idle with no approach, then bad weather hold
        speed = 1'b0;
        fuel = 2'b01;
        @(negedge clk);
        check("release_valid", alloc_valid, 0);
        weather = 1'b0;
        @(negedge clk);
        for (int v = WXD; v >= 1; v--) begin
            for (int k = 0; k < TD; k++) begin
                check("wx_hold_active", timer_active, 1);
                check("wx_hold_value", timer_value, v);
                @(negedge clk);
            end
        end
        check("wx_grant_valid", alloc_valid, 1);
        check("wx_grant_runway", allocated_runway, 1);
        check("wx_grant_timer", timer_value, 0);

        // Excess fuel hold, preempted by an emergency
        weather = 1'b1;
        fuel = 2'b11;
        @(negedge clk);
        check("xfuel_idle_valid", alloc_valid, 0);
        @(negedge clk);
        check("xfuel_hold_value", timer_value, FD);
        check("xfuel_hold_active", timer_active, 1);
        repeat (3) @(negedge clk);
        emergency = 1'b1;
        @(negedge clk);
        check("preempt_runway", allocated_runway, 0);
        check("preempt_valid", alloc_valid, 1);
        check("preempt_timer_value", timer_value, 0);
        check("preempt_timer_active", timer_active, 0);

        // Takeoffs: weather hold from gate 1, then direct grants from gates 4 and 6
        emergency = 1'b0;
        fuel = 2'b01;
        takeoff_signal = 1'b1;
        gate_number = 3'd1;
        weather = 1'b0;
        wait_valid("takeoff_g1_wait", 60);
        check("takeoff_g1_runway", allocated_runway, 3);
        check("takeoff_g1_gate", allocated_gate, 1);
        gate_number = 3'd4;
        weather = 1'b1;
        wait_valid("takeoff_g4_wait", 5);
        check("takeoff_g4_runway", allocated_runway, 2);
        gate_number = 3'd6;
        wait_valid("takeoff_g6_wait", 5);
        check("takeoff_g6_runway", allocated_runway, 2);
        check("takeoff_g6_gate", allocated_gate, 6);

`ifdef ATC_GATE_TRACK_EN
        rst = 1'b1;
        takeoff_signal = 1'b0;
        speed = 1'b1;
        gate_number = 3'd5;
        @(negedge clk);
        rst = 1'b0;
        wait_valid("track_l1_wait", 5);
        check("track_l1_gate", allocated_gate, 0);
        gate_number = 3'd6;
        wait_valid("track_l2_wait", 5);
        check("track_l2_gate", allocated_gate, 1);
        takeoff_signal = 1'b1;
        gate_number = 3'd0;
        wait_valid("track_to_wait", 5);
        check("track_to_gate", allocated_gate, 0);
        takeoff_signal = 1'b0;
        gate_number = 3'd2;
        wait_valid("track_l3_wait", 5);
        check("track_l3_gate", allocated_gate, 0);
`endif

        // Randomized traffic; request fields change rarely so holds and grants get to play out
        for (int c = 0; c < 4000; c++) begin
            @(negedge clk);
            rst = ($urandom_range(0, 299) == 0);
            if ($urandom_range(0, 15) == 0) weather = ($urandom_range(0, 2) != 0);
            if ($urandom_range(0, 15) == 0) fuel = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 19) == 0) takeoff_signal = ~takeoff_signal;
            if ($urandom_range(0, 19) == 0) gate_number = 3'($urandom_range(0, 7));
            if (emergency) emergency = ($urandom_range(0, 3) != 0);
            else           emergency = ($urandom_range(0, 59) == 0);
            if ($urandom_range(0, 3) == 0) speed = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 3) == 0) range = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 3) == 0) altitude = ($urandom_range(0, 3) != 0);
        end

        @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
